// File: rtl/control_signal_pipe_if.sv
// Bundle for the decode-stage control path: instruction and bubble select in,
// decoded ID controls plus staged EX/MEM controls out.
interface control_signal_pipe_if;
  logic [31:0] in_instruction;
  logic        S;
  logic [3:0]  ID_opcode;
  logic        ID_AM;
  logic        ID_S_enable;
  logic        ID_load_instr;
  logic        ID_RF_enable;
  logic        ID_Size_enable;
  logic        ID_RW_enable;
  logic        ID_Enable_signal;
  logic        ID_BL_instr;
  logic        ID_B_instr;
  logic [3:0]  EX_opcode;
  logic        EX_AM;
  logic        EX_S_enable;
  logic        EX_load_instr;
  logic        EX_RF_enable;
  logic        EX_Size_enable;
  logic        EX_RW_enable;
  logic        EX_Enable_signal;
  logic        MEM_load_instr;
  logic        MEM_RF_enable;
  logic        MEM_Size_enable;
  logic        MEM_RW_enable;
  logic        MEM_Enable_signal;

  modport master (
    output in_instruction, S,
    input  ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
           ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr,
    input  EX_opcode, EX_AM, EX_S_enable, EX_load_instr, EX_RF_enable,
           EX_Size_enable, EX_RW_enable, EX_Enable_signal,
    input  MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable,
           MEM_Enable_signal
  );

  modport slave (
    input  in_instruction, S,
    output ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
           ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr,
    output EX_opcode, EX_AM, EX_S_enable, EX_load_instr, EX_RF_enable,
           EX_Size_enable, EX_RW_enable, EX_Enable_signal,
    output MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable,
           MEM_Enable_signal
  );
endinterface

// File: rtl/control_signal_pipe.sv
// Decode-stage control path: combinational decode, bubble mux, then the
// ID/EX and EX/MEM control registers (each stage keeps only what it still needs).
module control_signal_pipe (
  input logic                  clk,
  input logic                  R,
  control_signal_pipe_if.slave bus
);

  typedef struct packed {
    logic [3:0] opcode;
    logic       am;
    logic       s_enable;
    logic       load_instr;
    logic       rf_enable;
    logic       size_enable;
    logic       rw_enable;
    logic       enable_signal;
    logic       bl_instr;
    logic       b_instr;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic       am;
    logic       s_enable;
    logic       load_instr;
    logic       rf_enable;
    logic       size_enable;
    logic       rw_enable;
    logic       enable_signal;
  } ex_ctrl_t;

  typedef struct packed {
    logic load_instr;
    logic rf_enable;
    logic size_enable;
    logic rw_enable;
    logic enable_signal;
  } mem_ctrl_t;

  logic [31:0] instr_s;
  ctrl_t       dec_s;
  ctrl_t       id_s;
  ex_ctrl_t    ex_r;
  mem_ctrl_t   mem_r;
  logic        unused_bits_s;

  assign instr_s       = bus.in_instruction;
  // Condition field and operand fields play no part in control decode.
  assign unused_bits_s = ^{instr_s[31:28], instr_s[19:0]};

  // Instruction class decode into control signals.
  always_comb begin
    dec_s = '0;
    if (instr_s == 32'h0000_0000) begin
      dec_s = '0;
    end else begin
      case (instr_s[27:26])
        2'b00: begin
          dec_s.opcode    = instr_s[24:21];
          dec_s.am        = instr_s[25];
          dec_s.s_enable  = instr_s[20];
          // TST/TEQ/CMP/CMN (10xx) only set flags, no register write.
          dec_s.rf_enable = (instr_s[24:23] != 2'b10);
        end
        2'b01: begin
          dec_s.enable_signal = 1'b1;
          dec_s.load_instr    = instr_s[20];
          dec_s.rf_enable     = instr_s[20];
          dec_s.rw_enable     = ~instr_s[20];
          dec_s.size_enable   = instr_s[22];
          dec_s.am            = instr_s[25];
          dec_s.opcode        = instr_s[23] ? 4'b0100 : 4'b0010;
        end
        2'b10: begin
          if (instr_s[25]) begin
            dec_s.b_instr   = 1'b1;
            dec_s.bl_instr  = instr_s[24];
            dec_s.rf_enable = instr_s[24];
            dec_s.opcode    = 4'b0100;
          end else begin
            dec_s = '0;
          end
        end
        default: dec_s = '0;
      endcase
    end
  end

  // Bubble mux: S forces a NOP into the pipe.
  always_comb begin
    id_s = '0;
    if (bus.S) begin
      id_s = '0;
    end else begin
      id_s = dec_s;
    end
  end

  assign bus.ID_opcode        = id_s.opcode;
  assign bus.ID_AM            = id_s.am;
  assign bus.ID_S_enable      = id_s.s_enable;
  assign bus.ID_load_instr    = id_s.load_instr;
  assign bus.ID_RF_enable     = id_s.rf_enable;
  assign bus.ID_Size_enable   = id_s.size_enable;
  assign bus.ID_RW_enable     = id_s.rw_enable;
  assign bus.ID_Enable_signal = id_s.enable_signal;
  assign bus.ID_BL_instr      = id_s.bl_instr;
  assign bus.ID_B_instr       = id_s.b_instr;

  // ID/EX control register; branch flags are consumed in decode and dropped.
  always_ff @(posedge clk) begin
    if (R) begin
      ex_r <= '0;
    end else begin
      ex_r <= '{opcode:        id_s.opcode,
                am:            id_s.am,
                s_enable:      id_s.s_enable,
                load_instr:    id_s.load_instr,
                rf_enable:     id_s.rf_enable,
                size_enable:   id_s.size_enable,
                rw_enable:     id_s.rw_enable,
                enable_signal: id_s.enable_signal};
    end
  end

  // EX/MEM control register; ALU controls are no longer needed past EX.
  always_ff @(posedge clk) begin
    if (R) begin
      mem_r <= '0;
    end else begin
      mem_r <= '{load_instr:    ex_r.load_instr,
                 rf_enable:     ex_r.rf_enable,
                 size_enable:   ex_r.size_enable,
                 rw_enable:     ex_r.rw_enable,
                 enable_signal: ex_r.enable_signal};
    end
  end

  assign bus.EX_opcode         = ex_r.opcode;
  assign bus.EX_AM             = ex_r.am;
  assign bus.EX_S_enable       = ex_r.s_enable;
  assign bus.EX_load_instr     = ex_r.load_instr;
  assign bus.EX_RF_enable      = ex_r.rf_enable;
  assign bus.EX_Size_enable    = ex_r.size_enable;
  assign bus.EX_RW_enable      = ex_r.rw_enable;
  assign bus.EX_Enable_signal  = ex_r.enable_signal;

  assign bus.MEM_load_instr    = mem_r.load_instr;
  assign bus.MEM_RF_enable     = mem_r.rf_enable;
  assign bus.MEM_Size_enable   = mem_r.size_enable;
  assign bus.MEM_RW_enable     = mem_r.rw_enable;
  assign bus.MEM_Enable_signal = mem_r.enable_signal;

endmodule

// File: tb/tb_control_signal_pipe.sv
// Self-checking bench for control_signal_pipe: instruction-level model plus
// per-cycle compare, and directed vectors with hand-computed control values.
module tb_control_signal_pipe;

  logic clk;
  logic R;
  int   checks;
  int   failures;

  control_signal_pipe_if bus ();

  control_signal_pipe dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {opcode[3:0], AM, S_enable, load, RF, Size, RW, Enable, BL, B}
  localparam logic [12:0] L_ADDS = 13'b0100_1_1_0_1_0_0_0_0_0;
  localparam logic [12:0] L_CMP  = 13'b1010_0_1_0_0_0_0_0_0_0;
  localparam logic [12:0] L_LDR  = 13'b0100_0_0_1_1_0_0_1_0_0;
  localparam logic [12:0] L_STRB = 13'b0010_0_0_0_0_1_1_1_0_0;
  localparam logic [12:0] L_BL   = 13'b0100_0_0_0_1_0_0_0_1_1;
  localparam logic [12:0] L_B    = 13'b0100_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] L_ADDR = 13'b0100_0_0_0_1_0_0_0_0_0;
  localparam logic [12:0] L_MOVI = 13'b1101_1_0_0_1_0_0_0_0_0;

  // Behavioural decode straight from the instruction-class rules.
  function automatic logic [12:0] model(input logic [31:0] i, input logic s);
    logic [3:0] op;
    logic am, se, ld, rf, sz, rw, en, bl, b;
    op = 4'd0; am = 1'b0; se = 1'b0; ld = 1'b0; rf = 1'b0;
    sz = 1'b0; rw = 1'b0; en = 1'b0; bl = 1'b0; b = 1'b0;
    if (s || i == 32'd0) return 13'd0;
    if (i[27:26] == 2'b00) begin
      op = i[24:21]; am = i[25]; se = i[20];
      rf = !(op >= 4'd8 && op <= 4'd11);
    end else if (i[27:26] == 2'b01) begin
      en = 1'b1; ld = i[20]; rf = i[20]; rw = !i[20]; sz = i[22]; am = i[25];
      op = i[23] ? 4'd4 : 4'd2;
    end else if (i[27:25] == 3'b101) begin
      b = 1'b1; bl = i[24]; rf = i[24]; op = 4'd4;
    end
    return {op, am, se, ld, rf, sz, rw, en, bl, b};
  endfunction

  function automatic logic [10:0] to_ex(input logic [12:0] v);
    return v[12:2];
  endfunction

  function automatic logic [4:0] to_mem(input logic [10:0] v);
    return v[4:0];
  endfunction

  logic [12:0] id_vec;
  logic [10:0] ex_vec;
  logic [4:0]  mem_vec;
  assign id_vec  = {bus.ID_opcode, bus.ID_AM, bus.ID_S_enable, bus.ID_load_instr,
                    bus.ID_RF_enable, bus.ID_Size_enable, bus.ID_RW_enable,
                    bus.ID_Enable_signal, bus.ID_BL_instr, bus.ID_B_instr};
  assign ex_vec  = {bus.EX_opcode, bus.EX_AM, bus.EX_S_enable, bus.EX_load_instr,
                    bus.EX_RF_enable, bus.EX_Size_enable, bus.EX_RW_enable,
                    bus.EX_Enable_signal};
  assign mem_vec = {bus.MEM_load_instr, bus.MEM_RF_enable, bus.MEM_Size_enable,
                    bus.MEM_RW_enable, bus.MEM_Enable_signal};

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Pipeline expectations: queue of what each stage must hold.
  logic [10:0] exp_ex;
  logic [4:0]  exp_mem;
  logic        model_valid;
  initial model_valid = 1'b0;

  always @(posedge clk) begin
    if (R) begin
      exp_ex      <= 11'd0;
      exp_mem     <= 5'd0;
      model_valid <= 1'b1;
    end else begin
      exp_ex  <= to_ex(model(bus.in_instruction, bus.S));
      exp_mem <= to_mem(exp_ex);
    end
  end

  always @(negedge clk) begin
    chk("cyc_id", id_vec, model(bus.in_instruction, bus.S));
    if (model_valid) begin
      chk("cyc_ex", {2'b00, ex_vec}, {2'b00, exp_ex});
      chk("cyc_mem", {8'd0, mem_vec}, {8'd0, exp_mem});
    end
  end

  task automatic apply(input logic [31:0] i, input logic s, input logic r);
    @(posedge clk);
    #2;
    bus.in_instruction = i;
    bus.S = s;
    R = r;
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    R = 1'b1;
    bus.S = 1'b0;
    bus.in_instruction = 32'hDEAD_BEEF;

    chk("pin_adds", model(32'hE292_1005, 1'b0), L_ADDS);
    chk("pin_cmp",  model(32'hE151_0002, 1'b0), L_CMP);
    chk("pin_strb", model(32'hE541_0001, 1'b0), L_STRB);
    chk("pin_b",    model(32'hEA00_0002, 1'b0), L_B);

    apply(32'h1234_5678, 1'b0, 1'b1);
    apply(32'hE591_0004, 1'b0, 1'b1);
    chk("rst_ex",  {2'b00, ex_vec}, 13'd0);
    chk("rst_mem", {8'd0, mem_vec}, 13'd0);

    apply(32'hE292_1005, 1'b0, 1'b0);
    chk("id_adds", id_vec, L_ADDS);
    chk("ex_after_rst", {2'b00, ex_vec}, 13'd0);
    apply(32'hE151_0002, 1'b0, 1'b0);
    chk("ex_adds", {2'b00, ex_vec}, {2'b00, L_ADDS[12:2]});
    chk("id_cmp", id_vec, L_CMP);
    apply(32'hE591_0004, 1'b0, 1'b0);
    chk("mem_adds", {8'd0, mem_vec}, {8'd0, 5'b0_1_0_0_0});
    chk("id_ldr", id_vec, L_LDR);
    apply(32'hE541_0001, 1'b0, 1'b0);
    chk("id_strb", id_vec, L_STRB);
    apply(32'hEB00_0002, 1'b0, 1'b0);
    chk("mem_ldr", {8'd0, mem_vec}, {8'd0, 5'b1_1_0_0_1});
    chk("id_bl", id_vec, L_BL);
    apply(32'hEA00_0002, 1'b0, 1'b0);
    chk("id_b", id_vec, L_B);
    chk("mem_strb", {8'd0, mem_vec}, {8'd0, 5'b0_0_1_1_1});
    apply(32'hE081_0002, 1'b0, 1'b0);
    chk("id_add_reg", id_vec, L_ADDR);
    chk("ex_b_dropped", {2'b00, ex_vec}, {2'b00, 11'b0100_0_0_0_0_0_0_0});
    apply(32'hE3A0_0001, 1'b0, 1'b0);
    chk("id_movi", id_vec, L_MOVI);
    apply(32'hEE00_0000, 1'b0, 1'b0);
    chk("id_cop_nop", id_vec, 13'd0);
    apply(32'hE890_0000, 1'b0, 1'b0);
    chk("id_ldm_nop", id_vec, 13'd0);

    apply(32'hE591_0004, 1'b0, 1'b0);
    chk("id_ldr2", id_vec, L_LDR);
    apply(32'hE591_0004, 1'b1, 1'b0);
    chk("id_bubble", id_vec, 13'd0);
    apply(32'hE591_0004, 1'b1, 1'b0);
    chk("ex_bubble", {2'b00, ex_vec}, 13'd0);
    apply(32'h0000_0000, 1'b0, 1'b0);
    chk("mem_bubble", {8'd0, mem_vec}, 13'd0);
    chk("id_zero", id_vec, 13'd0);

    apply(32'hE591_0004, 1'b0, 1'b0);
    apply(32'hE591_0004, 1'b0, 1'b0);
    apply(32'hE591_0004, 1'b0, 1'b1);
    apply(32'hE292_1005, 1'b0, 1'b0);
    chk("midrst_ex", {2'b00, ex_vec}, 13'd0);
    chk("midrst_mem", {8'd0, mem_vec}, 13'd0);
    apply(32'hE292_1005, 1'b0, 1'b0);
    chk("post_rst_ex", {2'b00, ex_vec}, {2'b00, L_ADDS[12:2]});
    chk("post_rst_mem", {8'd0, mem_vec}, 13'd0);
    apply(32'h0000_0000, 1'b0, 1'b0);
    chk("post_rst_mem2", {8'd0, mem_vec}, {8'd0, 5'b0_1_0_0_0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_signal_pipe.md
Name: control_signal_pipe

Overview:
- Decode stage control path for the pipelined ARM-subset CPU.
- Combinationally decodes the 32-bit instruction held in the IF/ID register into control signals.
- Passes those signals through a bubble (NOP) mux.
- Carries them through the ID/EX and EX/MEM pipeline registers, dropping signals each stage no longer needs.

Parameters:
- none (all widths fixed)

Ports:
- clk  in  1  system clock; registers update on rising edge
- R  in  1  reset; synchronous, active-high
- in_instruction  in  32  instruction from IF/ID
- S  in  1  bubble select; 1 forces all ID_* outputs to 0
- ID_opcode  out  4  ALU opcode after mux (combinational)
- ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr  out  1 each  decoded controls after mux (combinational)
- EX_opcode  out  4  registered ID_opcode
- EX_AM, EX_S_enable, EX_load_instr, EX_RF_enable, EX_Size_enable, EX_RW_enable, EX_Enable_signal  out  1 each  registered ID_* counterparts
- MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable, MEM_Enable_signal  out  1 each  registered EX_* counterparts

Behaviour:
- Decode is purely combinational. Default for every signal is 0. Condition field [31:28] is ignored. Let I = in_instruction.
- Data processing (I[27:26]=00, excluding I==0):
  - opcode=I[24:21], AM=I[25], S_enable=I[20]
  - RF_enable=1, except opcode 1000–1011 (TST/TEQ/CMP/CMN), where RF_enable=0
  - all memory signals = 0
- Load/store (I[27:26]=01):
  - Enable_signal=1, load_instr=I[20], RF_enable=I[20]
  - RW_enable=~I[20] (1 = write/store), Size_enable=I[22] (1 = byte)
  - AM=I[25], S_enable=0
  - opcode=0100 if U (I[23])=1, else 0010
- Branch (I[27:25]=101):
  - B_instr=1, BL_instr=I[24], RF_enable=I[24] (link write)
  - opcode=0100, all other signals 0
- I==32'h0 and all other encodings: all signals 0 (NOP).
- Mux: S=1 → every ID_* output 0 regardless of I. S=0 → ID_* equal decoded values. ID_* are combinational and do not depend on clk or R.
- ID/EX register (posedge clk):
  - R=1 → all EX_* = 0
  - else EX_* ← ID_* (opcode, AM, S_enable, load_instr, RF_enable, Size_enable, RW_enable, Enable_signal)
  - BL/B are not propagated.
- EX/MEM register (posedge clk):
  - R=1 → all MEM_* = 0
  - else MEM_* ← EX_* (load_instr, RF_enable, Size_enable, RW_enable, Enable_signal)
- Latency: ID→EX 1 cycle; ID→MEM 2 cycles. No stall/enable input; both registers load every cycle.
- Reset asserted mid-stream clears both stages on the same edge. The first non-zero EX_* appears one edge after R deasserts; MEM_* follows one edge later.
- Power-up register contents are undefined until the first reset edge.

Test Plan:
- R=1 for 2 edges, any I → all EX_* and MEM_* = 0. Deassert R with I=E2921005 (ADDS r1,r2,#5) → ID_opcode=0100, AM=1, S_enable=1, RF_enable=1. Next edge: EX_* match. Following edge: MEM_RF_enable=1, other MEM_* = 0.
- I=E1510002 (CMP r1,r2) → ID_opcode=1010, S_enable=1, RF_enable=0, AM=0, all memory signals 0.
- I=E5910004 (LDR r0,[r1,#4]) → load_instr=1, RF_enable=1, Enable_signal=1, RW_enable=0, Size_enable=0, opcode=0100. Two edges later: MEM_load_instr=1, MEM_Enable_signal=1.
- I=E5410001 (STRB r0,[r1,#-1]) → RW_enable=1, Size_enable=1, Enable_signal=1, load_instr=0, RF_enable=0, opcode=0010.
- I=EB000002 (BL) → BL_instr=1, B_instr=1, RF_enable=1, opcode=0100. I=EA000002 (B) → BL_instr=0, RF_enable=0.
- With the LDR instruction applied, set S=1 → all ID_* = 0 immediately. Next edge: EX_* = 0. Edge after: MEM_* = 0. Also apply I=00000000 with S=0 → all ID_* = 0.
